bus_xcvr_ctl: RTL and testbench
===============================

# bus_xcvr_ctl

Sequencer that owns the DR/CS_n controls of a 74LS245-style bidirectional byte transceiver between the FPGA-side A bus and the board-side B bus. Accepts single read/write requests over a valid/ready handshake, performs safe direction turnaround, runs a strobe/acknowledge bus cycle with minimum access time and timeout, and returns read data or completion status. Sits between the CPU bus-interface logic and each 245 transceiver pair on the Sun-2 data path.

## Interface
- DW, 8, data width (one 245 = 8)
- TURN, 1, dead cycles with CS_n high on a direction change (≥1)
- ACC, 2, minimum strobe-low cycles (≥1)
- TMO, 255, strobe-low cycles before a timeout error (TMO > ACC)

- clk  in  1  system clock
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready at rising edge
- req_write  in  1  1 = write (A→B), 0 = read (B→A)
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle completion pulse (no backpressure)
- rsp_rdata  out  DW  read data, valid with rsp_valid; 0 for writes and errors
- rsp_err  out  1  timeout, valid with rsp_valid
- a_out  out  DW  FPGA drive value on A side
- a_oe  out  1  FPGA A-side output enable
- a_in  in  DW  A-side sampled value
- dr  out  1  transceiver direction, 1 = A→B
- cs_n  out  1  transceiver enable, active low
- strobe_n  out  1  board bus data strobe, active low
- ack_n  in  1  board bus acknowledge, asynchronous, active low

## Operation
- States: IDLE, TURN, SETUP, STROBE, HOLD.
- Reset: state IDLE, dr=0, cs_n=1, strobe_n=1, a_oe=0, a_out=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters 0, ack synchronizer preset to 1. reset_n assertion mid-cycle aborts immediately to these values; no response is issued.
- req_ready = (state==IDLE) & ack_sync (synchronized ack_n high). A new cycle never starts while the previous ack is still asserted.
- IDLE, accept: latch write flag and wdata. If req_write != dr → TURN, dr <= req_write on the transition; else → SETUP.
- TURN: cs_n=1, a_oe=0, strobe_n=1 for exactly TURN cycles, then SETUP.
- SETUP (1 cycle): cs_n=0; a_oe=write; a_out=wdata when write. strobe_n=1.
- STROBE: strobe_n=0, cs_n=0, a_oe=write. Cycle counter from 0. Exit to HOLD when count ≥ ACC-1 and ack_sync==0; read captures a_in into rsp_rdata on that exit edge. If count reaches TMO-1 without ack → HOLD with error flag, rdata=0.
- HOLD (1 cycle): strobe_n=1, cs_n=0, a_oe/a_out held (data hold). Then IDLE with rsp_valid=1, rsp_err=error flag for one cycle.
- IDLE after a cycle: cs_n=1, a_oe=0, dr retains last direction.
- Invariant: a_oe=1 only when dr=1 and cs_n=0; dr changes only while cs_n=1 and a_oe=0.
- ack_n arriving late after timeout: ignored; next request waits for ack_sync high.

## Timing
- All control outputs registered, glitch-free.
- ack_n through 2-flop synchronizer: 2-cycle latency to ack_sync.
- Same direction, device acking combinationally from strobe_n, ACC=2: accept at edge ending cycle 0; SETUP cycle 1; STROBE cycles 2–4; HOLD cycle 5; rsp_valid cycle 6; req_ready again cycle 7.
- Direction change adds exactly TURN cycles.
- Timeout: STROBE lasts exactly TMO cycles; rsp_valid TMO+2 cycles after SETUP.
- Counter width $clog2(TMO+1); no wrap (saturates at exit).

## Structure
- Package bus_xcvr_pkg: state enum, direction constants DIR_A2B=1 / DIR_B2A=0.
- Sub-module ack_sync: 2-flop synchronizer, asynchronous active-low reset to 1.
- Single FSM plus one cycle counter shared by TURN and STROBE.

## Test plan
- Reset: hold reset_n low mid-STROBE → cs_n=1, strobe_n=1, dr=0, a_oe=0, no rsp_valid.
- Read after reset (dr already 0), a_in=8'hA5, combinational ack → no TURN, rsp_valid cycle 6, rsp_rdata=8'hA5, rsp_err=0.
- Write 8'h3C after a read, TURN=1 → one cycle cs_n=1 with dr=1, then a_oe=1, a_out=8'h3C during SETUP/STROBE/HOLD; rsp_rdata=0.
- ack_n never asserted, TMO=255 → strobe_n low exactly 255 cycles, rsp_err=1, rsp_rdata=0.
- ack_n held low after cycle → req_ready stays 0 with req_valid=1 until ack_n high + 2 cycles.
- Back-to-back alternating read/write ×16 with random ack delay → bus monitor finds no cycle with a_oe=1 and dr=0, no dr change while cs_n=0.

Source files
------------

// File: rtl/bus_xcvr_ctl_pkg.sv
// Shared types for the 245 transceiver sequencer: FSM states and direction codes.
package bus_xcvr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  // States in which the transceiver is enabled (cs_n low).
  function automatic logic drives_bus(input state_t s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/bus_xcvr_ctl_ack_sync.sv
// Two-flop synchronizer for the board acknowledge; resets to the idle (high) level.
module ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/bus_xcvr_ctl.sv
// DR/CS_n sequencer for a 245-style transceiver: one request at a time, safe
// direction turnaround, strobe/ack cycle with minimum access time and timeout.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// req_valid may be held without change until then. rsp_valid is a one-cycle
// pulse with no backpressure, rsp_rdata/rsp_err qualified by it.
module bus_xcvr_ctl
  import bus_xcvr_pkg::*;
#(
  parameter int DW   = 8,
  parameter int TURN = 1,
  parameter int ACC  = 2,
  parameter int TMO  = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [DW-1:0] a_out,
  output logic          a_oe,
  input  logic [DW-1:0] a_in,
  output logic          dr,
  output logic          cs_n,
  output logic          strobe_n,
  input  logic          ack_n,
  output state_t        dbg_state
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
  localparam logic [CW-1:0] ACC_LAST  = CW'(ACC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_ack_sync;
  logic          w_accept;
  logic          w_ok;
  logic          w_tmo;
  logic          w_wr_nxt;
  logic          r_wr;
  logic          r_err;
  logic          r_dr;
  logic          r_cs_n;
  logic          r_strobe_n;
  logic          r_a_oe;
  logic [DW-1:0] r_a_out;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [DW-1:0] r_rdata;

  ack_sync u_ack_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_async(ack_n),
    .o_sync (w_ack_sync)
  );

  // Holding off until the previous ack has gone away keeps a slow device's
  // late ack from completing the next cycle early.
  assign req_ready = (r_state == ST_IDLE) && w_ack_sync;
  assign w_accept  = req_valid && req_ready;
  assign w_wr_nxt  = w_accept ? req_write : r_wr;

  always_comb begin
    w_nxt = r_state;
    w_ok  = 1'b0;
    w_tmo = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_nxt = (req_write != r_dr) ? ST_TURN : ST_SETUP;
      ST_TURN:   if (r_cnt == TURN_LAST) w_nxt = ST_SETUP;
      ST_SETUP:  w_nxt = ST_STROBE;
      ST_STROBE: begin
        if ((r_cnt >= ACC_LAST) && !w_ack_sync) begin
          w_nxt = ST_HOLD;
          w_ok  = 1'b1;
        end else if (r_cnt == TMO_LAST) begin
          w_nxt = ST_HOLD;
          w_tmo = 1'b1;
        end
      end
      ST_HOLD:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      r_dr        <= DIR_B2A;
      r_cs_n      <= 1'b1;
      r_strobe_n  <= 1'b1;
      r_a_oe      <= 1'b0;
      r_a_out     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_nxt;
      // One counter serves TURN and STROBE; it restarts on every state change.
      if (w_nxt != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_TURN) || (r_state == ST_STROBE)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_wr    <= req_write;
        r_dr    <= req_write;
        r_err   <= 1'b0;
        r_a_out <= req_write ? req_wdata : '0;
      end
      if (w_ok) begin
        r_rdata <= r_wr ? '0 : a_in;
      end
      if (w_tmo) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
      // Outputs follow the next state so they are glitch-free flop outputs.
      r_cs_n      <= !drives_bus(w_nxt);
      r_strobe_n  <= (w_nxt != ST_STROBE);
      r_a_oe      <= (w_wr_nxt == DIR_A2B) && drives_bus(w_nxt);
      r_rsp_valid <= (r_state == ST_HOLD);
      r_rsp_err   <= (r_state == ST_HOLD) && r_err;
    end
  end

  assign dr        = r_dr;
  assign cs_n      = r_cs_n;
  assign strobe_n  = r_strobe_n;
  assign a_oe      = r_a_oe;
  assign a_out     = r_a_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_xcvr_ctl.sv
// Self-checking bench for bus_xcvr_ctl: vector table, directed corner cases,
// randomized alternating traffic against a transaction-level timing model.
module tb_bus_xcvr_ctl;
  import bus_xcvr_pkg::*;

  localparam int DW   = 8;
  localparam int TURN = 1;
  localparam int ACC  = 2;
  localparam int TMO  = 255;
  localparam int W    = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [DW-1:0] a_out;
  logic          a_oe;
  logic [DW-1:0] a_in;
  logic          dr;
  logic          cs_n;
  logic          strobe_n;
  logic          ack_n;
  state_t        dbg_state;

  // ack_mode: 0 = ack follows strobe_n combinationally, 1 = delayed device, 2 = manual
  int            ack_mode;
  logic          ack_drv;
  int            dev_d;
  int            dev_wait;
  assign ack_n = (ack_mode == 0) ? strobe_n : ack_drv;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en;
  int   mon_bad = 0;
  logic prev_dr = 1'b0;
  logic prev_cs_n = 1'b1;
  logic model_dr;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic [7:0] ain;
    int         mode;
    int         d;
    int         exp_lat;
    int         exp_strobes;
    int         exp_turns;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  bus_xcvr_ctl #(.DW(DW), .TURN(TURN), .ACC(ACC), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .a_out(a_out), .a_oe(a_oe),
    .a_in(a_in), .dr(dr), .cs_n(cs_n), .strobe_n(strobe_n), .ack_n(ack_n),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Board device: acks dev_d cycles after it sees strobe low, releases with strobe.
  initial begin
    dev_wait = 0;
    forever begin
      @(negedge clk);
      if (ack_mode == 1) begin
        if (strobe_n) begin
          ack_drv  = 1'b1;
          dev_wait = dev_d;
        end else if (dev_wait == 0) begin
          ack_drv = 1'b0;
        end else begin
          dev_wait--;
        end
      end
    end
  end

  // Bus safety monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_oe && (!dr || cs_n)) mon_bad++;
      if ((dr != prev_dr) && !(cs_n && prev_cs_n && !a_oe)) mon_bad++;
    end
    prev_dr   = dr;
    prev_cs_n = cs_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_strobes(input int mode, input int d);
    int s;
    if (mode == 2) return TMO;
    s = (mode == 0) ? 3 : d + 3;
    if (s < ACC) s = ACC;
    return s;
  endfunction

  // Issues one request at a negedge and observes the bus cycle up to the response.
  task automatic run_txn(input logic wr, input logic [7:0] wd, input logic [7:0] ain,
                         output int lat, output int strobes, output int turns,
                         output int bad, output logic [7:0] rd, output logic er,
                         output logic rdy_at, output logic rdy_nxt, output logic pulse_nxt);
    int   n;
    logic seen;
    lat = -1; strobes = 0; turns = 0; bad = 0; rd = '0; er = 1'b0;
    rdy_at = 1'b0; rdy_nxt = 1'b0; pulse_nxt = 1'b1; seen = 1'b0;
    a_in = ain; req_write = wr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < 600; c++) begin
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; er = rsp_err; rdy_at = req_ready;
        break;
      end
      if (cs_n) begin
        if (!seen) begin
          turns++;
          if (dr != wr) bad++;
        end
      end else begin
        seen = 1'b1;
        if ((a_oe != wr) || (dr != wr)) bad++;
        if (wr && (a_out != wd)) bad++;
        if (!strobe_n) strobes++;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      rdy_nxt = req_ready;
      pulse_nxt = rsp_valid;
    end
  endtask

  initial begin
    int lat, strobes, turns, bad, n, rsp_cnt, s, t;
    logic [7:0] rd, wd, ain;
    logic er, rdy_at, rdy_nxt, pulse_nxt, wr;
    logic [W-1:0] e;

    vecs[0] = '{1'b0, 8'h00, 8'hA5, 0, 0, 6,   3,   0, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 8'h00, 0, 0, 7,   3,   1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h55, 8'h77, 1, 2, 8,   5,   0, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h0F, 1, 1, 8,   4,   1, 8'h0F, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'hFF, 2, 0, 258, 255, 0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'hC3, 8'h00, 0, 0, 7,   3,   1, 8'h00, 1'b0};

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; a_in = '0;
    ack_mode = 2; ack_drv = 1'b1; dev_d = 0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_strobe_n", int'(strobe_n), 1);
    chk("rst_dr", int'(dr), 0);
    chk("rst_a_oe", int'(a_oe), 0);
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_req_ready", int'(req_ready), 1);

    // ---------------- vector table ----------------
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ack_mode = vecs[i].mode;
      dev_d    = vecs[i].d;
      if (vecs[i].mode == 2) ack_drv = 1'b1;
      run_txn(vecs[i].wr, vecs[i].wd, vecs[i].ain, lat, strobes, turns, bad,
              rd, er, rdy_at, rdy_nxt, pulse_nxt);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_strobe_cycles", i), strobes, vecs[i].exp_strobes);
      chk($sformatf("vec%0d_turn_cycles", i), turns, vecs[i].exp_turns);
      chk($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_err", i), int'(er), int'(vecs[i].exp_err));
      chk($sformatf("vec%0d_drive", i), bad, 0);
      chk($sformatf("vec%0d_ready_at_rsp", i), int'(rdy_at), (vecs[i].mode == 2) ? 1 : 0);
      chk($sformatf("vec%0d_ready_after", i), int'(rdy_nxt), 1);
      chk($sformatf("vec%0d_rsp_one_cycle", i), int'(pulse_nxt), 0);
      model_dr = vecs[i].wr;
    end

    // ---------------- ack held low blocks the next request ----------------
    ack_mode = 2; ack_drv = 1'b0;
    repeat (3) @(negedge clk);
    req_write = 1'b0; req_valid = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready || !cs_n) n++;
    end
    chk("ackheld_blocked", n, 0);
    ack_mode = 0;
    @(negedge clk);
    chk("ackheld_ready_1clk", int'(req_ready), 0);
    @(negedge clk);
    chk("ackheld_ready_2clk", int'(req_ready), 1);
    run_txn(1'b0, 8'h00, 8'h5A, lat, strobes, turns, bad, rd, er, rdy_at, rdy_nxt, pulse_nxt);
    chk("ackheld_latency", lat, 7);
    chk("ackheld_rdata", int'(rd), 8'h5A);
    model_dr = 1'b0;

    // ---------------- randomized alternating traffic ----------------
    ack_mode = 1;
    for (int i = 0; i < 16; i++) begin
      wr  = (i % 2 == 1);
      wd  = 8'($urandom);
      ain = 8'($urandom);
      dev_d = $urandom_range(0, 5);
      s = model_strobes(1, dev_d);
      t = (wr != model_dr) ? TURN : 0;
      exp_q.push_back({16'(t + s + 3), 3'd0, 4'(t), 1'b0, (wr ? 8'h00 : ain)});
      model_dr = wr;
      run_txn(wr, wd, ain, lat, strobes, turns, bad, rd, er, rdy_at, rdy_nxt, pulse_nxt);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_latency", i), lat, int'(e[31:16]));
      chk($sformatf("rnd%0d_turn_cycles", i), turns, int'(e[12:9]));
      chk($sformatf("rnd%0d_rdata", i), int'(rd), int'(e[7:0]));
      chk($sformatf("rnd%0d_err", i), int'(er), int'(e[8]));
      chk($sformatf("rnd%0d_drive", i), bad, 0);
    end
    mon_en = 1'b0;
    chk("bus_monitor_violations", mon_bad, 0);

    // ---------------- reset asserted mid-STROBE ----------------
    ack_mode = 2; ack_drv = 1'b1;
    req_write = 1'b1; req_wdata = 8'h99; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (strobe_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("midrst_in_strobe", int'(strobe_n), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", int'(cs_n), 1);
    chk("midrst_strobe_n", int'(strobe_n), 1);
    chk("midrst_dr", int'(dr), 0);
    chk("midrst_a_oe", int'(a_oe), 0);
    chk("midrst_a_out", int'(a_out), 0);
    chk("midrst_state", int'(dbg_state), int'(ST_IDLE));
    rsp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    reset_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    chk("midrst_no_response", rsp_cnt, 0);
    chk("midrst_cs_n_after", int'(cs_n), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
